// File: rtl/lfsr_param_engine.sv
// Runtime-configurable LFSR engine: Galois/Fibonacci stepping, nibble-serial state and
// tap loading, optional lock-up reseed, hold, and hardware period measurement.
module lfsr_param_engine #(
  parameter int               WIDTH = 16,
  parameter int               DIN_W = 4,
  parameter logic [WIDTH-1:0] SEED  = 16'h0001,
  parameter logic [WIDTH-1:0] TAPS  = 16'hB400
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       mode,
  input  logic [DIN_W-1:0] data_in,
  output logic [WIDTH-1:0] state,
  output logic             bit_out,
  output logic             lockup,
  output logic             period_done,
  output logic [WIDTH-1:0] period
);

  localparam int NCHUNK = WIDTH / DIN_W;
  localparam int PTR_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  localparam logic [1:0] MODE_RUN   = 2'b00;
  localparam logic [1:0] MODE_STATE = 2'b01;
  localparam logic [1:0] MODE_TAPS  = 2'b10;
  localparam logic [1:0] MODE_CFG   = 2'b11;

  logic [WIDTH-1:0] taps;
  logic [WIDTH-1:0] start;
  logic [WIDTH-1:0] step_count;
  logic [2:0]       cfg;
  logic [PTR_W-1:0] ptr;
  logic [1:0]       prev_mode;

  logic             hold;
  logic             auto_reseed;
  logic             galois;
  logic [PTR_W-1:0] eff_ptr;
  logic [PTR_W-1:0] ptr_wrap;
  logic [WIDTH-1:0] loaded_state;
  logic [WIDTH-1:0] loaded_taps;
  logic [WIDTH-1:0] step_state;

  function automatic logic [WIDTH-1:0] galois_step(input logic [WIDTH-1:0] s,
                                                   input logic [WIDTH-1:0] t);
    logic [WIDTH-1:0] n;
    n[WIDTH-1] = s[0];
    for (int i = 0; i < WIDTH-1; i++) n[i] = s[i+1] ^ (s[0] & t[i]);
    return n;
  endfunction

  function automatic logic [WIDTH-1:0] fib_step(input logic [WIDTH-1:0] s,
                                                input logic [WIDTH-1:0] t);
    return {^(s & t), s[WIDTH-1:1]};
  endfunction

  assign {hold, auto_reseed, galois} = cfg;
  assign bit_out = state[0];
  assign lockup  = (state == '0);

  // A mode change restarts chunk addressing so the first write of a new load lands in chunk 0.
  always_comb begin
    eff_ptr  = (mode != prev_mode) ? '0 : ptr;
    ptr_wrap = (eff_ptr == PTR_W'(NCHUNK-1)) ? '0 : eff_ptr + 1'b1;
    loaded_state = state;
    loaded_state[eff_ptr*DIN_W +: DIN_W] = data_in;
    loaded_taps = taps;
    loaded_taps[eff_ptr*DIN_W +: DIN_W] = data_in;
    step_state = galois ? galois_step(state, taps) : fib_step(state, taps);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= SEED;
      taps        <= TAPS;
      cfg         <= 3'b001;
      start       <= SEED;
      step_count  <= '0;
      period      <= '0;
      period_done <= 1'b0;
      ptr         <= '0;
      prev_mode   <= MODE_RUN;
    end else begin
      period_done <= 1'b0;
      prev_mode   <= mode;
      case (mode)
        MODE_RUN: begin
          ptr <= '0;
          if (!hold) begin
            if (lockup && auto_reseed) begin
              state      <= SEED;
              start      <= SEED;
              step_count <= '0;
            end else begin
              state <= step_state;
              if (step_state == start) begin
                period      <= step_count + 1'b1;
                period_done <= 1'b1;
                step_count  <= '0;
              end else if (step_count != '1) begin
                // Saturates when non-invertible taps never return to start.
                step_count <= step_count + 1'b1;
              end
            end
          end
        end
        MODE_STATE: begin
          state      <= loaded_state;
          start      <= loaded_state;
          step_count <= '0;
          ptr        <= ptr_wrap;
        end
        MODE_TAPS: begin
          taps <= loaded_taps;
          ptr  <= ptr_wrap;
        end
        default: begin
          cfg <= data_in[2:0];
          ptr <= '0;
        end
      endcase
    end
  end

endmodule
